// File: rtl/menu_pkg.sv
// Shared types and constants for the SDRAM probe/clear sequencer.
// Probe step tables, cfg bit positions and the clear-limit rule.
package menu_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_P_ISSUE,
        S_P_GUARD,
        S_P_WAIT,
        S_C_CHECK,
        S_C_ISSUE,
        S_C_GUARD,
        S_C_WAIT,
        S_C_GAP,
        S_DONE
    } probe_state_t;

    localparam int PROBE_STEPS = 7;

    // Steps 0..3 are writes, 4..6 are the read-backs.
    localparam logic [2:0] PROBE_FIRST_READ = 3'd4;
    localparam logic [2:0] PROBE_LAST       = 3'd6;

    // W0, W1, W2, decoy W3, then R0, R1, R2.
    localparam logic [26:0] PROBE_ADDR [PROBE_STEPS] = '{
        27'h4000000, 27'h2000000, 27'h0000000, 27'h1000000,
        27'h4000000, 27'h2000000, 27'h0000000
    };

    localparam logic [15:0] PROBE_DATA [PROBE_STEPS] = '{
        16'd3128, 16'd2064, 16'd1032, 16'd12345,
        16'd3128, 16'd2064, 16'd1032
    };

    localparam int CFG_PROBE_DONE = 15;
    localparam int CFG_CLEAR_DONE = 14;

    // Words to zero: the largest region found, or a fixed
    // override when simulating.
    function automatic logic [27:0] clear_limit(
        input logic [2:0] flags,
        input int         sim_words
    );
        if (sim_words != 0)
            return 28'(sim_words);
        else if (flags[2])
            return 28'h8000000;
        else if (flags[1])
            return 28'h4000000;
        else if (flags[0])
            return 28'h2000000;
        else
            return 28'h0;
    endfunction

endpackage

// File: rtl/sdram_probe_clear_if.sv
// Word-port bundle between the sequencer and the SDRAM controller.
// master = command issuer, slave = controller side.
interface sdram_probe_clear_if;

    logic        sd_ready;
    logic [15:0] sd_dout;
    logic [26:0] sd_addr;
    logic [15:0] sd_din;
    logic        sd_we;
    logic        sd_rd;

    modport master (
        input  sd_ready,
        input  sd_dout,
        output sd_addr,
        output sd_din,
        output sd_we,
        output sd_rd
    );

    modport slave (
        output sd_ready,
        output sd_dout,
        input  sd_addr,
        input  sd_din,
        input  sd_we,
        input  sd_rd
    );

endinterface

// File: rtl/sdram_probe_clear.sv
// Power-up owner of the SDRAM word port: aliasing size probe,
// then a zero sweep of the detected range.
module sdram_probe_clear
    import menu_pkg::*;
#(
    parameter int CLEAR_GAP       = 0,
    parameter int SIM_CLEAR_WORDS = 0
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 hold,
    sdram_probe_clear_if.master  sd,
    output logic [15:0]          cfg,
    output logic                 busy
);

    localparam int GW = (CLEAR_GAP > 1) ? $clog2(CLEAR_GAP) : 1;

    probe_state_t state_q, state_d;
    logic [2:0]   step_q, step_d;
    logic [27:0]  addr_q, addr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]  cfg_q, cfg_d;
    logic [26:0]  sd_addr_q, sd_addr_d;
    logic [15:0]  sd_din_q, sd_din_d;
    logic         we_q, we_d;
    logic         rd_q, rd_d;

    logic         can_issue;
    logic         is_wr;
    logic         hit;
    logic [27:0]  limit;

    assign can_issue = sd.sd_ready && !hold;
    assign is_wr     = (step_q < PROBE_FIRST_READ);
    assign hit       = (sd.sd_dout == PROBE_DATA[step_q]);
    assign limit     = clear_limit(cfg_q[2:0], SIM_CLEAR_WORDS);

    assign sd.sd_addr = sd_addr_q;
    assign sd.sd_din  = sd_din_q;
    assign sd.sd_we   = we_q;
    assign sd.sd_rd   = rd_q;
    assign cfg        = cfg_q;
    assign busy       = (state_q != S_DONE);

    // State, counters and registered bus outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_INIT;
            step_q    <= '0;
            addr_q    <= '0;
            gap_q     <= '0;
            cfg_q     <= '0;
            sd_addr_q <= '0;
            sd_din_q  <= '0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            addr_q    <= addr_d;
            gap_q     <= gap_d;
            cfg_q     <= cfg_d;
            sd_addr_q <= sd_addr_d;
            sd_din_q  <= sd_din_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
        end
    end

    // Next-state, command issue and cfg updates.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        addr_d    = addr_q;
        gap_d     = gap_q;
        cfg_d     = cfg_q;
        sd_addr_d = sd_addr_q;
        sd_din_d  = sd_din_q;
        we_d      = 1'b0;
        rd_d      = 1'b0;

        unique case (state_q)
            S_INIT: begin
                step_d = '0;
                if (sd.sd_ready)
                    state_d = S_P_ISSUE;
            end

            S_P_ISSUE: begin
                if (can_issue) begin
                    sd_addr_d = PROBE_ADDR[step_q];
                    if (is_wr)
                        sd_din_d = PROBE_DATA[step_q];
                    we_d    = is_wr;
                    rd_d    = !is_wr;
                    state_d = S_P_GUARD;
                end
            end

            // Controller may not have dropped ready yet.
            S_P_GUARD: state_d = S_P_WAIT;

            S_P_WAIT: begin
                if (sd.sd_ready) begin
                    case (step_q)
                        3'd4:    cfg_d[2] = hit;
                        3'd5:    cfg_d[1] = hit;
                        3'd6:    cfg_d[0] = hit;
                        default: ;
                    endcase
                    if (step_q == PROBE_LAST) begin
                        cfg_d[CFG_PROBE_DONE] = 1'b1;
                        state_d = S_C_CHECK;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_P_ISSUE;
                    end
                end
            end

            S_C_CHECK: begin
                addr_d = '0;
                if (limit == '0) begin
                    cfg_d[CFG_CLEAR_DONE] = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_C_ISSUE;
                end
            end

            S_C_ISSUE: begin
                if (can_issue) begin
                    sd_addr_d = addr_q[26:0];
                    sd_din_d  = '0;
                    we_d      = 1'b1;
                    state_d   = S_C_GUARD;
                end
            end

            S_C_GUARD: state_d = S_C_WAIT;

            S_C_WAIT: begin
                if (sd.sd_ready) begin
                    if (addr_q + 28'd1 == limit) begin
                        cfg_d[CFG_CLEAR_DONE] = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 28'd1;
                        if (CLEAR_GAP > 0) begin
                            gap_d   = GW'(CLEAR_GAP - 1);
                            state_d = S_C_GAP;
                        end else begin
                            state_d = S_C_ISSUE;
                        end
                    end
                end
            end

            // Throttle between clear writes.
            S_C_GAP: begin
                if (gap_q == '0)
                    state_d = S_C_ISSUE;
                else
                    gap_d = gap_q - GW'(1);
            end

            S_DONE: begin
                if (start) begin
                    cfg_d   = '0;
                    state_d = S_INIT;
                end
            end

            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_sdram_probe_clear.sv
// Bench: two sequencer instances against behavioural SDRAM models,
// table-driven scenarios plus hold / reset / restart sequences.
module tb_sdram_probe_clear;

    localparam int M27   = 0;
    localparam int M26   = 1;
    localparam int M25   = 2;
    localparam int M24   = 3;
    localparam int NODEV = 4;
    localparam int NCLR  = 16;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n;
    logic        start;
    logic        hold;
    logic [15:0] cfg_a, cfg_b;
    logic        busy_a, busy_b;

    sdram_probe_clear_if bus_a ();
    sdram_probe_clear_if bus_b ();

    sdram_probe_clear #(
        .CLEAR_GAP      (2),
        .SIM_CLEAR_WORDS(NCLR)
    ) u_dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .start  (start),
        .hold   (hold),
        .sd     (bus_a),
        .cfg    (cfg_a),
        .busy   (busy_a)
    );

    sdram_probe_clear #(
        .CLEAR_GAP      (0),
        .SIM_CLEAR_WORDS(0)
    ) u_nodev (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .start  (1'b0),
        .hold   (1'b0),
        .sd     (bus_b),
        .cfg    (cfg_b),
        .busy   (busy_b)
    );

    // ---------------- SDRAM model A: sized, aliasing ----------------
    int          cur_mode = M27;
    int          cur_lat  = 0;
    int          cnt_a    = 0;
    int          init_a   = 0;
    logic [15:0] dout_a   = '0;
    logic [15:0] last_a   = '0;
    logic [15:0] mem [logic [26:0]];

    function automatic logic [26:0] eff(input logic [26:0] a);
        case (cur_mode)
            M26:     return a & 27'h3FFFFFF;
            M25:     return a & 27'h1FFFFFF;
            M24:     return a & 27'h0FFFFFF;
            default: return a;
        endcase
    endfunction

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_a  <= 0;
            init_a <= 3;
        end else begin
            if (init_a > 0)
                init_a <= init_a - 1;
            if (bus_a.sd_we || bus_a.sd_rd)
                cnt_a <= (cur_lat == 0) ? 0
                         : int'($urandom_range(0, cur_lat));
            else if (cnt_a > 0)
                cnt_a <= cnt_a - 1;
            if (bus_a.sd_we) begin
                last_a <= bus_a.sd_din;
                if (cur_mode != NODEV)
                    mem[eff(bus_a.sd_addr)] = bus_a.sd_din;
            end
            if (bus_a.sd_rd) begin
                if (cur_mode == NODEV)
                    dout_a <= last_a;
                else if (mem.exists(eff(bus_a.sd_addr)))
                    dout_a <= mem[eff(bus_a.sd_addr)];
                else
                    dout_a <= 16'hDEAD;
            end
        end
    end

    assign bus_a.sd_ready = reset_n && (init_a == 0) && (cnt_a == 0);
    assign bus_a.sd_dout  = dout_a;

    // ---------------- SDRAM model B: nothing fitted ----------------
    logic [15:0] last_b = '0;
    always @(posedge clk_sys)
        if (bus_b.sd_we)
            last_b <= bus_b.sd_din;
    assign bus_b.sd_ready = 1'b1;
    assign bus_b.sd_dout  = last_b;

    // ---------------- command monitor ----------------
    typedef struct {
        logic        we;
        logic [26:0] addr;
        logic [15:0] din;
        int          cyc;
    } cmd_t;

    cmd_t        log_q[$];
    cmd_t        exp_q[$];
    int          cyc = 0;
    logic [15:0] cfg_at_clear = '0;
    int          nb_we = 0;
    int          nb_rd = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (bus_a.sd_we || bus_a.sd_rd) begin
                if (log_q.size() == 7)
                    cfg_at_clear = cfg_a;
                log_q.push_back('{bus_a.sd_we, bus_a.sd_addr,
                                  bus_a.sd_din, cyc});
            end
            if (bus_b.sd_we) nb_we++;
            if (bus_b.sd_rd) nb_rd++;
        end
    end

    // ---------------- reference sequence ----------------
    logic [26:0] p_addr [7] = '{27'h4000000, 27'h2000000, 27'h0,
                                27'h1000000, 27'h4000000,
                                27'h2000000, 27'h0};
    logic [15:0] p_data [7] = '{16'd3128, 16'd2064, 16'd1032,
                                16'd12345, 16'd0, 16'd0, 16'd0};

    task automatic build_exp(input int lim);
        exp_q.delete();
        for (int i = 0; i < 7; i++)
            exp_q.push_back('{(i < 4), p_addr[i], p_data[i], 0});
        for (int a = 0; a < lim; a++)
            exp_q.push_back('{1'b1, 27'(a), 16'h0, 0});
    endtask

    // ---------------- checking ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    task automatic check_log(input string nm);
        int bad;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= log_q.size()) begin
                bad = i;
                break;
            end
            if (log_q[i].we !== exp_q[i].we ||
                log_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && log_q[i].din !== exp_q[i].din)) begin
                bad = i;
                break;
            end
        end
        if (bad < 0 && log_q.size() != exp_q.size())
            bad = exp_q.size();
        check(nm, bad, -1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},   int'(bus_a.sd_we),   0);
        check({tag, "_rd"},   int'(bus_a.sd_rd),   0);
        check({tag, "_addr"}, int'(bus_a.sd_addr), 0);
        check({tag, "_din"},  int'(bus_a.sd_din),  0);
        check({tag, "_cfg"},  int'(cfg_a),         0);
        check({tag, "_busy"}, int'(busy_a),        1);
    endtask

    task automatic do_reset(input int mode, input int lat);
        @(negedge clk_sys);
        reset_n  = 1'b0;
        hold     = 1'b0;
        start    = 1'b0;
        cur_mode = mode;
        cur_lat  = lat;
        mem.delete();
        repeat (2) @(negedge clk_sys);
        log_q.delete();
        cfg_at_clear = '0;
        nb_we = 0;
        nb_rd = 0;
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input int pct, input int budget,
                             output bit ok);
        int r;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_sys);
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
            r = int'($urandom_range(0, 99));
            hold = (r < pct);
        end
        hold = 1'b0;
    endtask

    task automatic wait_clear_wr(input int a, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_sys);
            if (bus_a.sd_we && cfg_a[15] &&
                bus_a.sd_addr == 27'(a)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int          mode;
        int          lat;
        int          hold_pct;
        bit          chk_gap;
        logic [15:0] exp_cfg;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit ok;
        int nstb;
        int gbad;

        tbl[0] = '{M27,   0, 0,  1'b1, 16'h8007};
        tbl[1] = '{M26,   2, 30, 1'b0, 16'h8003};
        tbl[2] = '{M25,   1, 20, 1'b0, 16'h8001};
        tbl[3] = '{M24,   3, 0,  1'b0, 16'h8000};
        tbl[4] = '{NODEV, 0, 25, 1'b0, 16'h8000};
        tbl[5] = '{M27, int'($urandom_range(0, 3)), 40, 1'b0, 16'h8007};

        reset_n = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_reset_vals("rst");

        // No device, unthrottled, no override: clear skipped.
        reset_n = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_sys);
            if (!busy_b) begin
                ok = 1'b1;
                break;
            end
        end
        check("nodev_done", int'(ok), 1);
        check("nodev_cfg", int'(cfg_b), 16'hC000);
        check("nodev_writes", nb_we, 4);
        check("nodev_reads", nb_rd, 3);

        for (int i = 0; i < 6; i++) begin
            do_reset(tbl[i].mode, tbl[i].lat);
            build_exp(NCLR);
            wait_done(tbl[i].hold_pct, 4000, ok);
            check($sformatf("v%0d_done", i), int'(ok), 1);
            check($sformatf("v%0d_probe_cfg", i),
                  int'(cfg_at_clear), int'(tbl[i].exp_cfg));
            check($sformatf("v%0d_final_cfg", i),
                  int'(cfg_a), int'(tbl[i].exp_cfg | 16'h4000));
            check_log($sformatf("v%0d_cmds", i));
            if (tbl[i].chk_gap) begin
                gbad = 0;
                for (int k = 8; k < log_q.size(); k++)
                    if (log_q[k].cyc - log_q[k-1].cyc != 5)
                        gbad++;
                check("gap_spacing", gbad, 0);
            end
        end

        // Hold raised in the guard cycle of the write to 5,
        // plus a start pulse outside DONE.
        do_reset(M27, 0);
        build_exp(NCLR);
        wait_clear_wr(5, ok);
        check("hold_reach", int'(ok), 1);
        hold  = 1'b1;
        start = 1'b1;
        nstb  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            start = 1'b0;
            if (bus_a.sd_we || bus_a.sd_rd)
                nstb++;
        end
        check("hold_no_strobe", nstb, 0);
        hold = 1'b0;
        wait_done(0, 2000, ok);
        check("hold_done", int'(ok), 1);
        check_log("hold_cmds");
        check("hold_cfg", int'(cfg_a), 16'hC007);

        // Reset mid-sweep: outputs drop at once, then full re-probe.
        do_reset(M26, 1);
        build_exp(NCLR);
        wait_clear_wr(8, ok);
        check("mid_reach", int'(ok), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk_sys);
        log_q.delete();
        cfg_at_clear = '0;
        mem.delete();
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_done(20, 4000, ok);
        check("mid_done", int'(ok), 1);
        check_log("mid_cmds");
        check("mid_cfg", int'(cfg_a), 16'hC003);

        // Start in DONE re-runs probe and clear.
        log_q.delete();
        cfg_at_clear = '0;
        @(negedge clk_sys);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        check("restart_busy", int'(busy_a), 1);
        check("restart_cfg_clr", int'(cfg_a), 0);
        wait_done(10, 4000, ok);
        check("restart_done", int'(ok), 1);
        check_log("restart_cmds");
        check("restart_probe_cfg", int'(cfg_at_clear), 16'h8003);
        check("restart_cfg", int'(cfg_a), 16'hC003);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
